// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared constants, select type and digit slicing for the digit scan sequencer
package scan_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int SEL_W      = 2;
  localparam int DEFAULT_DW = 4;
  // Widest digit the slicing helper supports; narrower digits are zero-extended into it.
  localparam int MAX_DW     = 32;

  typedef logic [SEL_W-1:0] sel_t;

  function automatic logic [MAX_DW-1:0] digit_slice(
    input logic [NUM_DIGITS*MAX_DW-1:0] active,
    input sel_t                         sel,
    input int                           dw
  );
    logic [NUM_DIGITS*MAX_DW-1:0] shifted;
    shifted = active >> (int'(sel) * dw);
    return shifted[MAX_DW-1:0];
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// rtl/scan_prescaler.sv - slot prescaler: counts 0..DIV-1 while enabled, tick on the last count
module scan_prescaler #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      if (tick) cnt_d = '0;
      else      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/digit_scan_sequencer.sv
// rtl/digit_scan_sequencer.sv - scans four digits to a 2-to-4 decoder with frame-aligned loads
// Optional select-change blanking is enabled by defining BLANKING_EN.
module digit_scan_sequencer
  import scan_pkg::*;
#(
  parameter int DW    = DEFAULT_DW,
  parameter int DIV   = 50000,
  parameter int BLANK = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [NUM_DIGITS*DW-1:0] load_data,
  output logic [SEL_W-1:0]       sel,
  output logic [DW-1:0]          digit_data,
  output logic                   sel_valid,
  output logic                   frame_done
);

  logic tick;
  logic boundary;
  logic accept;

  sel_t                     sel_q, sel_d;
  logic [NUM_DIGITS*DW-1:0] active_q, active_d;
  logic [NUM_DIGITS*DW-1:0] pending_q, pending_d;
  logic                     pending_full_q, pending_full_d;
  logic                     sel_valid_q, sel_valid_d;
  logic                     frame_done_q, frame_done_d;

  scan_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

  assign boundary   = tick && (sel_q == sel_t'(NUM_DIGITS - 1));
  assign load_ready = !pending_full_q;
  assign accept     = load_valid && load_ready;

  // A load can only complete while pending is empty, so it never collides with the
  // pending->active transfer, which needs pending full.
  always_comb begin
    sel_d          = sel_q;
    active_d       = active_q;
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    frame_done_d   = 1'b0;
    if (tick) sel_d = sel_q + sel_t'(1);
    if (boundary) begin
      frame_done_d = 1'b1;
      if (pending_full_q) begin
        active_d       = pending_q;
        pending_full_d = 1'b0;
      end
    end
    if (accept) begin
      pending_d      = load_data;
      pending_full_d = 1'b1;
    end
  end

`ifdef BLANKING_EN
  localparam int BW = $clog2(BLANK + 1);

  logic [BW-1:0] blank_q, blank_d;

  always_comb begin
    blank_d = '0;
    if (en) begin
      if (tick)                blank_d = BW'(BLANK);
      else if (blank_q != '0)  blank_d = blank_q - BW'(1);
    end
    sel_valid_d = en && (blank_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) blank_q <= '0;
    else     blank_q <= blank_d;
  end
`else
  always_comb begin
    sel_valid_d = en;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q          <= '0;
      active_q       <= '0;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      sel_valid_q    <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      sel_q          <= sel_d;
      active_q       <= active_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      sel_valid_q    <= sel_valid_d;
      frame_done_q   <= frame_done_d;
    end
  end

  logic [NUM_DIGITS*MAX_DW-1:0] active_ext;
  logic [MAX_DW-1:0]            slice;

  always_comb begin
    active_ext                   = '0;
    active_ext[NUM_DIGITS*DW-1:0] = active_q;
    slice                        = digit_slice(active_ext, sel_q, DW);
    digit_data                   = slice[DW-1:0];
  end

  assign sel        = sel_q;
  assign sel_valid  = sel_valid_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_digit_scan_sequencer.sv
// tb/tb_digit_scan_sequencer.sv - directed self-checking bench for digit_scan_sequencer
module tb_digit_scan_sequencer;

  logic        clk;
  logic        rst;
  logic        en;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic [1:0]  sel;
  logic [3:0]  digit_data;
  logic        sel_valid;
  logic        frame_done;

  int total;
  int bad;
  int n;

  digit_scan_sequencer #(
    .DW    (4),
    .DIV   (4),
    .BLANK (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .sel        (sel),
    .digit_data (digit_data),
    .sel_valid  (sel_valid),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // n counts rising edges since the last reset release; sampling happens on the falling edge.
  task automatic goto_edge(input int target);
    while (n < target) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    n          = 0;
    rst        = 1'b1;
    en         = 1'b0;
    load_valid = 1'b0;
    load_data  = 16'h0000;

    repeat (2) @(negedge clk);
    chk("rst_sel",        32'(sel),        0);
    chk("rst_digit",      32'(digit_data), 0);
    chk("rst_sel_valid",  32'(sel_valid),  0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_load_ready", 32'(load_ready), 1);

    // 1: free-running scan, empty active register
    rst = 1'b0;
    en  = 1'b1;
    goto_edge(1);
    chk("t1_sel_valid",   32'(sel_valid),  1);
    chk("t1_sel_e1",      32'(sel),        0);
    goto_edge(3);
    chk("t1_sel_e3",      32'(sel),        0);
    goto_edge(4);
    chk("t1_sel_e4",      32'(sel),        1);
    goto_edge(8);
    chk("t1_sel_e8",      32'(sel),        2);
    goto_edge(12);
    chk("t1_sel_e12",     32'(sel),        3);
    chk("t1_digit_e12",   32'(digit_data), 0);
    goto_edge(15);
    chk("t1_fd_e15",      32'(frame_done), 0);
    goto_edge(16);
    chk("t1_sel_e16",     32'(sel),        0);
    chk("t1_fd_e16",      32'(frame_done), 1);
    goto_edge(17);
    chk("t1_fd_e17",      32'(frame_done), 0);

    // 2: mid-frame load waits for the boundary
    goto_edge(21);
    load_valid = 1'b1;
    load_data  = 16'h4321;
    goto_edge(22);
    load_valid = 1'b0;
    load_data  = 16'hDEAD;
    chk("t2_ready_low",   32'(load_ready), 0);
    chk("t2_digit_hold",  32'(digit_data), 0);
    goto_edge(31);
    chk("t2_digit_e31",   32'(digit_data), 0);
    goto_edge(32);
    chk("t2_fd_e32",      32'(frame_done), 1);
    chk("t2_digit0",      32'(digit_data), 4'h1);
    chk("t2_ready_back",  32'(load_ready), 1);
    goto_edge(36);
    chk("t2_digit1",      32'(digit_data), 4'h2);
    goto_edge(40);
    chk("t2_digit2",      32'(digit_data), 4'h3);
    goto_edge(44);
    chk("t2_digit3",      32'(digit_data), 4'h4);

    // 3: second load stalls behind a full pending buffer
    load_valid = 1'b1;
    load_data  = 16'hAAAA;
    goto_edge(45);
    load_data  = 16'hBBBB;
    chk("t3_ready_full",  32'(load_ready), 0);
    goto_edge(47);
    chk("t3_digit_e47",   32'(digit_data), 4'h4);
    goto_edge(48);
    chk("t3_digit_a0",    32'(digit_data), 4'hA);
    chk("t3_ready_e48",   32'(load_ready), 1);
    goto_edge(49);
    load_valid = 1'b0;
    load_data  = 16'h0000;
    chk("t3_ready_e49",   32'(load_ready), 0);
    goto_edge(52);
    chk("t3_digit_a1",    32'(digit_data), 4'hA);
    goto_edge(63);
    chk("t3_digit_a3",    32'(digit_data), 4'hA);
    goto_edge(64);
    chk("t3_digit_b0",    32'(digit_data), 4'hB);
    goto_edge(68);
    chk("t3_digit_b1",    32'(digit_data), 4'hB);

    // 4: load completing in the boundary cycle lands one frame later
    goto_edge(79);
    load_valid = 1'b1;
    load_data  = 16'h5678;
    goto_edge(80);
    load_valid = 1'b0;
    load_data  = 16'h0000;
    chk("t4_fd_e80",      32'(frame_done), 1);
    chk("t4_digit_e80",   32'(digit_data), 4'hB);
    chk("t4_ready_e80",   32'(load_ready), 0);
    goto_edge(95);
    chk("t4_digit_e95",   32'(digit_data), 4'hB);
    goto_edge(96);
    chk("t4_digit_e96",   32'(digit_data), 4'h8);
    goto_edge(100);
    chk("t4_digit_e100",  32'(digit_data), 4'h7);

    // 5: pause at sel=2, cnt=1; a load is still accepted while paused
    goto_edge(105);
    chk("t5_sel_e105",    32'(sel),        2);
    en = 1'b0;
    goto_edge(106);
    chk("t5_valid_off",   32'(sel_valid),  0);
    chk("t5_sel_e106",    32'(sel),        2);
    goto_edge(107);
    load_valid = 1'b1;
    load_data  = 16'h9ABC;
    goto_edge(108);
    load_valid = 1'b0;
    chk("t5_ready_e108",  32'(load_ready), 0);
    goto_edge(115);
    chk("t5_sel_e115",    32'(sel),        2);
    chk("t5_valid_e115",  32'(sel_valid),  0);
    en = 1'b1;
    goto_edge(116);
    chk("t5_valid_on",    32'(sel_valid),  1);
    chk("t5_sel_e116",    32'(sel),        2);
    goto_edge(117);
    chk("t5_sel_e117",    32'(sel),        2);
    goto_edge(118);
    chk("t5_sel_e118",    32'(sel),        3);
    chk("t5_digit_e118",  32'(digit_data), 4'h5);

    // 6: asynchronous reset with pending full
    goto_edge(119);
    rst = 1'b1;
    #1;
    chk("t6_sel",         32'(sel),        0);
    chk("t6_digit",       32'(digit_data), 0);
    chk("t6_sel_valid",   32'(sel_valid),  0);
    chk("t6_frame_done",  32'(frame_done), 0);
    chk("t6_load_ready",  32'(load_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    n   = 0;
    goto_edge(4);
    chk("t6_sel_e4",      32'(sel),        1);
    chk("t6_digit_e4",    32'(digit_data), 0);
    goto_edge(16);
    chk("t6_fd_e16",      32'(frame_done), 1);
    chk("t6_digit_e16",   32'(digit_data), 0);
    chk("t6_ready_e16",   32'(load_ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
